// File: rtl/serial_uart.sv
// Full-duplex 8N1 UART: registered-output transmitter plus a mid-bit sampling
// receiver with a two-flop input synchronizer, sharing one baud configuration.
module serial_uart #(
   parameter int CLK_FREQ  = 48_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_tx,
   input  logic       i_rx,
   output logic       o_wr,
   output logic [7:0] o_data
);

   localparam int DIV  = CLK_FREQ / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);

   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV);
   localparam logic [CW-1:0] HALF_LOAD = CW'(HALF);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [0:0] TX_IDLE  = 1'b0;
   localparam logic [0:0] TX_SHIFT = 1'b1;

   localparam logic [2:0] RX_IDLE      = 3'd0;
   localparam logic [2:0] RX_START     = 3'd1;
   localparam logic [2:0] RX_DATA      = 3'd2;
   localparam logic [2:0] RX_STOP      = 3'd3;
   localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

   // ---------------- transmitter ----------------
   logic [0:0]    tx_state;
   logic [9:0]    tx_shreg;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;

   assign o_busy = (tx_state == TX_SHIFT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge value of every other register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_state <= TX_IDLE;
         tx_shreg <= '1;
         tx_bit   <= '0;
         tx_cnt   <= '0;
         o_tx     <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (i_wr) begin
                  tx_shreg <= {1'b1, i_data, 1'b0};
                  tx_bit   <= '0;
                  tx_cnt   <= '0;
                  o_tx     <= 1'b0;
                  tx_state <= TX_SHIFT;
               end
            end
            TX_SHIFT: begin
               if (tx_cnt == DIV_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 4'd9) begin
                     o_tx     <= 1'b1;
                     tx_state <= TX_IDLE;
                  end else begin
                     // o_tx is registered, so it takes the bit that becomes bit 0
                     tx_bit   <= tx_bit + 1'b1;
                     tx_shreg <= {1'b1, tx_shreg[9:1]};
                     o_tx     <= tx_shreg[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- receiver ----------------
   logic [1:0]    rx_sync;
   logic          rx_s;
   logic [2:0]    rx_state;
   logic [2:0]    rx_bit;
   logic [CW-1:0] rx_cnt;
   logic [7:0]    rx_shreg;

   assign rx_s = rx_sync[1];

   // Synchronizer resets to the idle-high line level so reset never fakes a start bit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) rx_sync <= 2'b11;
      else       rx_sync <= {rx_sync[0], i_rx};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_state <= RX_IDLE;
         rx_bit   <= '0;
         rx_cnt   <= '0;
         rx_shreg <= '0;
         o_wr     <= 1'b0;
         o_data   <= 8'h00;
      end else begin
         o_wr <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_cnt   <= HALF_LOAD;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == CNT_ONE) begin
                  if (!rx_s) begin
                     rx_cnt   <= DIV_LOAD;
                     rx_bit   <= '0;
                     rx_state <= RX_DATA;
                  end else begin
                     rx_state <= RX_IDLE;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == CNT_ONE) begin
                  rx_cnt   <= DIV_LOAD;
                  rx_shreg <= {rx_s, rx_shreg[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == CNT_ONE) begin
                  if (rx_s) begin
                     o_data   <= rx_shreg;
                     o_wr     <= 1'b1;
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_state <= RX_WAIT_HIGH;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            RX_WAIT_HIGH: begin
               if (rx_s) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_uart.sv
// Directed bench for serial_uart at DIV = 4 (500 kHz clock, 115200 baud):
// reset, TX waveform, loopback, glitch, framing error and busy lockout.
module tb_serial_uart;

   localparam int CLK_FREQ  = 500_000;
   localparam int BAUD_RATE = 115_200;
   localparam int DIV       = 4;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_wr;
   logic [7:0] i_data;
   logic       o_busy;
   logic       o_tx;
   logic       i_rx;
   logic       o_wr;
   logic [7:0] o_data;

   logic       loop_en;
   logic       rx_drv;

   int         checks   = 0;
   int         failures = 0;
   int         wr_count = 0;
   logic [7:0] last_wr_data = 8'h00;

   assign i_rx = loop_en ? o_tx : rx_drv;

   serial_uart #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_wr  (i_wr),
      .i_data(i_data),
      .o_busy(o_busy),
      .o_tx  (o_tx),
      .i_rx  (i_rx),
      .o_wr  (o_wr),
      .o_data(o_data)
   );

   always #5 i_clk = ~i_clk;

   // Strobes are sampled mid-cycle, so each one-clock pulse is counted once.
   always @(negedge i_clk) begin
      if (o_wr === 1'b1) begin
         wr_count++;
         last_wr_data = o_data;
      end
   end

   function automatic logic [39:0] tx_wave(input logic [7:0] d);
      logic [9:0]  f;
      logic [39:0] w;
      f = {1'b1, d, 1'b0};
      for (int i = 0; i < 40; i++) w[i] = f[i / DIV];
      return w;
   endfunction

   task automatic tx_frame(input logic [7:0] d, input string name);
      logic [39:0] wave;
      int          busy_cycles;
      @(negedge i_clk);
      i_wr   = 1'b1;
      i_data = d;
      @(posedge i_clk);
      #1;
      i_wr   = 1'b0;
      i_data = 8'h00;
      busy_cycles = 0;
      for (int k = 0; k < 40; k++) begin
         wave[k] = o_tx;
         if (o_busy === 1'b1) busy_cycles++;
         @(posedge i_clk);
         #1;
      end
      checks++;
      if (wave !== tx_wave(d)) begin
         failures++;
         $display("FAIL %s_wave: got %h expected %h", name, wave, tx_wave(d));
      end
      checks++;
      if (busy_cycles != 40) begin
         failures++;
         $display("FAIL %s_busy_len: got %0d expected 40", name, busy_cycles);
      end
      checks++;
      if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
         failures++;
         $display("FAIL %s_end_idle: busy=%b tx=%b expected busy=0 tx=1", name, o_busy, o_tx);
      end
   endtask

   task automatic rx_send(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         @(negedge i_clk);
         rx_drv = f[b];
         repeat (DIV - 1) @(negedge i_clk);
      end
   endtask

   task automatic test_reset;
      i_rst   = 1'b1;
      i_wr    = 1'b0;
      i_data  = 8'h00;
      loop_en = 1'b0;
      rx_drv  = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      checks++;
      if (o_tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", o_tx); end
      checks++;
      if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      checks++;
      if (o_wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b expected 0", o_wr); end
      checks++;
      if (o_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", o_data); end
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (3) @(negedge i_clk);
   endtask

   task automatic test_reset_midframe;
      @(negedge i_clk);
      i_wr   = 1'b1;
      i_data = 8'hC3;
      @(posedge i_clk);
      #1;
      i_wr = 1'b0;
      // Edge 17 after acceptance lies inside data bit 3, which is 0 for 0xC3.
      repeat (17) @(posedge i_clk);
      #1;
      checks++;
      if (o_tx !== 1'b0) begin failures++; $display("FAIL midframe_bit3: got %b expected 0", o_tx); end
      #2;
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_tx !== 1'b1) begin failures++; $display("FAIL midframe_rst_tx: got %b expected 1", o_tx); end
      checks++;
      if (o_busy !== 1'b0) begin failures++; $display("FAIL midframe_rst_busy: got %b expected 0", o_busy); end
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
      tx_frame(8'h5A, "post_reset");
   endtask

   task automatic test_tx_single;
      repeat (2) @(negedge i_clk);
      tx_frame(8'h4B, "tx_K");
   endtask

   task automatic test_loopback;
      int pulses;
      int last_pos;
      pulses   = 0;
      last_pos = 0;
      @(negedge i_clk);
      loop_en = 1'b1;
      i_wr    = 1'b1;
      i_data  = 8'h4B;
      // Accept on edge 1; each strobe lands 41 edges after its frame's acceptance.
      for (int i = 1; i <= 800; i++) begin
         @(posedge i_clk);
         #1;
         if (o_wr === 1'b1) begin
            pulses++;
            checks++;
            if (o_data !== 8'h4B) begin
               failures++;
               $display("FAIL loop_data: edge %0d got %h expected 4b", i, o_data);
            end
            checks++;
            if (last_pos == 0) begin
               if (i != 42) begin
                  failures++;
                  $display("FAIL loop_first_pos: got edge %0d expected edge 42", i);
               end
            end else if (i - last_pos != 41) begin
               failures++;
               $display("FAIL loop_period: got %0d expected 41", i - last_pos);
            end
            last_pos = i;
         end
      end
      checks++;
      if (pulses != 19) begin failures++; $display("FAIL loop_count: got %0d expected 19", pulses); end
      @(negedge i_clk);
      i_wr = 1'b0;
      repeat (60) @(negedge i_clk);
      loop_en = 1'b0;
      rx_drv  = 1'b1;
      repeat (4) @(negedge i_clk);
   endtask

   task automatic test_glitch;
      int base;
      base = wr_count;
      @(negedge i_clk);
      rx_drv = 1'b0;
      @(negedge i_clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge i_clk);
      checks++;
      if (wr_count != base) begin
         failures++;
         $display("FAIL glitch_no_wr: got %0d strobes expected 0", wr_count - base);
      end
      rx_send(8'hA5, 1'b1);
      @(negedge i_clk);
      rx_drv = 1'b1;
      repeat (8) @(negedge i_clk);
      checks++;
      if (wr_count != base + 1) begin
         failures++;
         $display("FAIL glitch_then_frame_count: got %0d strobes expected 1", wr_count - base);
      end
      checks++;
      if (last_wr_data !== 8'hA5) begin
         failures++;
         $display("FAIL glitch_then_frame_data: got %h expected a5", last_wr_data);
      end
      checks++;
      if (o_data !== 8'hA5) begin
         failures++;
         $display("FAIL glitch_then_frame_hold: got %h expected a5", o_data);
      end
   endtask

   task automatic test_framing;
      int base;
      base = wr_count;
      rx_send(8'h3C, 1'b0);
      @(negedge i_clk);
      rx_drv = 1'b1;
      repeat (12) @(negedge i_clk);
      checks++;
      if (wr_count != base) begin
         failures++;
         $display("FAIL framing_no_wr: got %0d strobes expected 0", wr_count - base);
      end
      checks++;
      if (o_data !== 8'hA5) begin
         failures++;
         $display("FAIL framing_data_kept: got %h expected a5", o_data);
      end
      rx_send(8'h81, 1'b1);
      @(negedge i_clk);
      rx_drv = 1'b1;
      repeat (8) @(negedge i_clk);
      checks++;
      if (wr_count != base + 1) begin
         failures++;
         $display("FAIL framing_recover_count: got %0d strobes expected 1", wr_count - base);
      end
      checks++;
      if (last_wr_data !== 8'h81) begin
         failures++;
         $display("FAIL framing_recover_data: got %h expected 81", last_wr_data);
      end
      checks++;
      if (o_data !== 8'h81) begin
         failures++;
         $display("FAIL framing_recover_hold: got %h expected 81", o_data);
      end
   endtask

   task automatic test_busy_lockout;
      logic [9:0] bits;
      logic       stayed_idle;
      @(negedge i_clk);
      i_wr   = 1'b1;
      i_data = 8'h55;
      @(posedge i_clk);
      #1;
      i_wr = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k % DIV == DIV / 2) bits[k / DIV] = o_tx;
         if (k == 4) begin
            i_wr   = 1'b1;
            i_data = 8'hAA;
         end
         if (k == 5) begin
            i_wr   = 1'b0;
            i_data = 8'h00;
         end
         @(posedge i_clk);
         #1;
      end
      checks++;
      if (bits !== 10'b1_0101_0101_0) begin
         failures++;
         $display("FAIL lockout_frame: got %b expected 1010101010", bits);
      end
      checks++;
      if (o_busy !== 1'b0) begin
         failures++;
         $display("FAIL lockout_busy_end: got %b expected 0", o_busy);
      end
      stayed_idle = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (o_tx !== 1'b1 || o_busy !== 1'b0) stayed_idle = 1'b0;
         @(posedge i_clk);
         #1;
      end
      checks++;
      if (stayed_idle !== 1'b1) begin
         failures++;
         $display("FAIL lockout_not_queued: got activity after frame expected idle line");
      end
   endtask

   initial begin
      test_reset();
      test_reset_midframe();
      test_tx_single();
      test_loopback();
      test_glitch();
      test_framing();
      test_busy_lockout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/serial_uart.md
# serial_uart

Full-duplex 8N1 UART core: one transmitter and one receiver sharing a clock, reset and baud configuration. The transmitter serialises bytes handed over by a write strobe. The receiver deserialises the line and presents each good byte with a one-cycle strobe. It sits between on-chip byte producers/consumers and the FPGA's serial pins, and can be looped back (o_tx → i_rx) for self-test.

## Interface
- CLK_FREQ, 48_000_000 — clock frequency in Hz.
- BAUD_RATE, 115_200 — line rate in bits/s.
- Derived: DIV = CLK_FREQ / BAUD_RATE (integer, truncating), clocks per bit; HALF = DIV / 2. Requirement: DIV ≥ 2.

Ports:
- i_clk  in  1  system clock; all logic rising-edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wr  in  1  transmit request; accepted on an edge where o_busy = 0.
- i_data  in  8  byte to transmit; sampled at acceptance.
- o_busy  out  1  transmitter is shifting a frame.
- o_tx  out  1  serial output, idle high.
- i_rx  in  1  serial input, asynchronous to i_clk, idle high.
- o_wr  out  1  one-cycle strobe: o_data holds a newly received byte.
- o_data  out  8  last good received byte.

## Operation
- Frame: start bit (0), 8 data bits LSB first, one stop bit (1). No parity.
- Each bit lasts exactly DIV clocks, in both the transmitter and the receiver.

Transmitter:
- States are IDLE and SHIFT. A 10-bit shift register is loaded with {1, data, 0}. A bit counter and a baud counter run alongside it.
- IDLE: o_busy = 0 and o_tx = 1. On an edge with i_wr = 1:
  - latch i_data;
  - go to SHIFT;
  - o_tx = 0 (start bit) and o_busy = 1, both from that edge.
- SHIFT: every DIV clocks, shift out the next bit. After the stop bit's DIV clocks, return to IDLE (o_busy = 0, o_tx = 1).
- i_wr while busy is ignored; it is not queued.
- With i_wr held high continuously, frames repeat with exactly one idle-high clock between them.

Receiver:
- i_rx passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized signal.
- IDLE: on a synchronized 0, go to START and load the baud counter with HALF.
- START: when the counter expires, re-sample the line.
  - Still 0: go to DATA with the counter at DIV.
  - Now 1: treat as a glitch and return to IDLE.
- DATA: every DIV clocks, sample one bit into the shift register, LSB first. After 8 bits, go to STOP.
- STOP: after DIV clocks, sample the line.
  - 1: o_data ← shift register and o_wr = 1 for exactly one clock; return to IDLE.
  - 0 (framing error): discard the byte, leave o_data unchanged, no o_wr. Go to WAIT_HIGH, which returns to IDLE once the line is sampled 1.
- o_data holds its value until the next good frame.

Reset (asynchronous, any time including mid-frame):
- Both sides go to IDLE immediately.
- o_tx = 1, o_busy = 0, o_wr = 0, o_data = 8'h00.
- The synchronizer is forced to 1.
- Any partial frame is dropped.

## Timing
- TX acceptance to o_tx falling: 0 cycles; it changes on the accepting edge.
- o_busy is high for exactly 10·DIV clocks per frame.
- RX latency, in clocks after the first i_rx falling edge seen at a clock edge: o_wr asserts at 2 + HALF + 9·DIV (+1 for the register stage), ±1 clock tolerance.
- Frame period with i_wr tied high: 10·DIV + 1 clocks.
- o_wr width is always 1 clock. No two strobes occur within 9·DIV clocks of each other.
- Receiver tolerance: the sample point is mid-bit, so a total baud mismatch of at least ±4% must decode correctly.

## Test plan
1. Reset mid-frame: assert i_rst during TX data bit 3 → o_tx = 1 and o_busy = 0 immediately; after release, the next i_wr sends a complete, correct frame.
2. Single TX byte, CLK_FREQ = 500_000, BAUD_RATE = 115_200 (DIV = 4), i_data = 0x4B (“K”):
   - o_tx shows 0,1,1,0,1,0,0,1,0,1, each bit 4 clocks;
   - o_busy is high for exactly 40 clocks.
3. Loopback (o_tx → i_rx), i_wr tied high, i_data = “K”, run 800 clocks:
   - o_wr pulses once per 41-clock frame, each time with o_data = 0x4B;
   - no other pulses.
4. Glitch rejection: drive i_rx low for 1 clock, then high → no o_wr; the receiver returns to IDLE and then decodes a following 0xA5 frame correctly.
5. Framing error: send 0x3C with stop bit = 0, then release the line high → no o_wr and o_data unchanged; a subsequent 0x81 frame yields o_wr with o_data = 0x81.
6. Busy lockout: pulse i_wr with 0x55 and, 5 clocks later, with 0xAA → only 0x55 is transmitted; 0xAA is ignored.
